// File: rtl/universal_ff_bank.sv
// Bank of WIDTH flip-flops with per-cycle D/T/JK/SR mode, change report and counter.
// Define UFF_SR_ERR_EN to add the sr_err flag for S=R=1 in SR mode.
module universal_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [WIDTH-1:0] chg,
    output logic [CNT_W-1:0] chg_cnt
`ifdef UFF_SR_ERR_EN
    ,
    output logic             sr_err
`endif
);

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] delta;
    logic             any_chg;
    logic             cnt_sat;

    always_comb begin
        qn = Q;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode)
                MODE_D:  qn[i] = a[i];
                MODE_T:  qn[i] = Q[i] ^ a[i];
                MODE_JK: begin
                    case ({a[i], b[i]})
                        2'b01:   qn[i] = 1'b0;
                        2'b10:   qn[i] = 1'b1;
                        2'b11:   qn[i] = ~Q[i];
                        default: qn[i] = Q[i];
                    endcase
                end
                MODE_SR: begin
                    // S=R=1 is illegal and simply keeps the stored bit
                    case ({a[i], b[i]})
                        2'b01:   qn[i] = 1'b0;
                        2'b10:   qn[i] = 1'b1;
                        default: qn[i] = Q[i];
                    endcase
                end
                default: qn[i] = Q[i];
            endcase
        end
    end

    assign delta   = qn ^ Q;
    assign any_chg = |delta;
    assign cnt_sat = (chg_cnt == CNT_MAX);
    assign Qn      = ~Q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q       <= RESET_VAL;
            chg     <= '0;
            chg_cnt <= '0;
        end else if (clr) begin
            Q       <= RESET_VAL;
            chg     <= Q ^ RESET_VAL;
            chg_cnt <= '0;
        end else if (en) begin
            Q   <= qn;
            chg <= delta;
            if (any_chg && !cnt_sat) begin
                chg_cnt <= chg_cnt + 1'b1;
            end
        end else begin
            chg <= '0;
        end
    end

`ifdef UFF_SR_ERR_EN
    logic sr_hit;

    assign sr_hit = en && !clr && (mode == MODE_SR) && (|(a & b));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_err <= 1'b0;
        end else begin
            sr_err <= sr_hit;
        end
    end
`endif

endmodule

// File: tb/tb_universal_ff_bank.sv
// Directed-vector bench for universal_ff_bank: default 8/16 instance plus
// a CNT_W=2 instance sharing the same stimulus for counter saturation.
module tb_universal_ff_bank;

    logic       clk;
    logic       reset;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;

    logic [7:0]  q0, qn0, chg0;
    logic [15:0] cnt0;
    logic [7:0]  q1, qn1, chg1;
    logic [1:0]  cnt1;
`ifdef UFF_SR_ERR_EN
    logic        sr_err0;
    logic        sr_err1;
`endif

    int vectors;
    int miscompares;

    universal_ff_bank #(
        .WIDTH(8),
        .CNT_W(16),
        .RESET_VAL(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .clr(clr),
        .mode(mode),
        .a(a),
        .b(b),
        .Q(q0),
        .Qn(qn0),
        .chg(chg0),
        .chg_cnt(cnt0)
`ifdef UFF_SR_ERR_EN
        ,
        .sr_err(sr_err0)
`endif
    );

    universal_ff_bank #(
        .WIDTH(8),
        .CNT_W(2),
        .RESET_VAL(8'h00)
    ) dut_sat (
        .clk(clk),
        .reset(reset),
        .en(en),
        .clr(clr),
        .mode(mode),
        .a(a),
        .b(b),
        .Q(q1),
        .Qn(qn1),
        .chg(chg1),
        .chg_cnt(cnt1)
`ifdef UFF_SR_ERR_EN
        ,
        .sr_err(sr_err1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic c,
                        input logic [1:0] m,
                        input logic [7:0] av,
                        input logic [7:0] bv);
        en   = e;
        clr  = c;
        mode = m;
        a    = av;
        b    = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [7:0] q,
                        input logic [7:0] ch, input logic [15:0] cn);
        check({tag, ".Q"}, {24'd0, q0}, {24'd0, q});
        check({tag, ".chg"}, {24'd0, chg0}, {24'd0, ch});
        check({tag, ".cnt"}, {16'd0, cnt0}, {16'd0, cn});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        mode  = 2'b00;
        a     = 8'h00;
        b     = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk3("rst", 8'h00, 8'h00, 16'd0);
        check("rst.Qn", {24'd0, qn0}, 32'h0000_00FF);
        check("rst.cnt_sat", {30'd0, cnt1}, 32'd0);
`ifdef UFF_SR_ERR_EN
        check("rst.sr_err", {31'd0, sr_err0}, 32'd0);
`endif
        reset = 1'b0;

        // T mode, all bits toggling
        step(1, 0, 2'b01, 8'hFF, 8'h00);
        chk3("t1", 8'hFF, 8'hFF, 16'd1);
        check("t1.Qn", {24'd0, qn0}, 32'h0000_0000);
        step(1, 0, 2'b01, 8'hFF, 8'h00);
        chk3("t2", 8'h00, 8'hFF, 16'd2);
        step(1, 0, 2'b01, 8'hFF, 8'h00);
        chk3("t3", 8'hFF, 8'hFF, 16'd3);

        // D load 0F, then JK per-bit mix
        step(1, 0, 2'b00, 8'h0F, 8'h00);
        chk3("d0f", 8'h0F, 8'hF0, 16'd4);
        step(1, 0, 2'b10, 8'hF0, 8'h3C);
        chk3("jk", 8'hF3, 8'hFC, 16'd5);
        step(1, 0, 2'b10, 8'h00, 8'h00);
        chk3("jk_hold", 8'hF3, 8'h00, 16'd5);

        // SR: illegal S=R=1 holds, then legal set/reset
        step(1, 0, 2'b00, 8'hA5, 8'h00);
        chk3("da5", 8'hA5, 8'h56, 16'd6);
        step(1, 0, 2'b11, 8'h81, 8'h81);
        chk3("sr_ill", 8'hA5, 8'h00, 16'd6);
`ifdef UFF_SR_ERR_EN
        check("sr_err.hi", {31'd0, sr_err0}, 32'd1);
`endif
        step(1, 0, 2'b11, 8'h02, 8'h04);
        chk3("sr_ok", 8'hA3, 8'h06, 16'd7);
`ifdef UFF_SR_ERR_EN
        check("sr_err.lo", {31'd0, sr_err0}, 32'd0);
`endif

        // priority: hold with en=0, then clr beats en
        step(1, 0, 2'b00, 8'h3C, 8'h00);
        chk3("d3c", 8'h3C, 8'h9F, 16'd8);
        step(0, 0, 2'b00, 8'hFF, 8'h00);
        chk3("hold", 8'h3C, 8'h00, 16'd8);
        step(1, 1, 2'b00, 8'hFF, 8'h00);
        chk3("clr", 8'h00, 8'h3C, 16'd0);
        check("clr.cnt_sat", {30'd0, cnt1}, 32'd0);

        // saturation on the CNT_W=2 instance
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 2'b01, 8'h01, 8'h00);
            check($sformatf("sat%0d", i), {30'd0, cnt1},
                  (i < 3) ? i : 3);
            check($sformatf("cnt%0d", i), {16'd0, cnt0}, i);
        end
        check("sat.Q", {24'd0, q1}, 32'h0000_0001);

        // async reset between edges
        step(1, 0, 2'b01, 8'hFF, 8'h00);
        chk3("pre_ar", 8'hFE, 8'hFF, 16'd6);
        #2;
        reset = 1'b1;
        #1;
        chk3("ar", 8'h00, 8'h00, 16'd0);
        check("ar.Qn", {24'd0, qn0}, 32'h0000_00FF);
        check("ar.cnt_sat", {30'd0, cnt1}, 32'd0);
        #1;
        reset = 1'b0;
        step(1, 0, 2'b01, 8'hFF, 8'h00);
        chk3("resume", 8'hFF, 8'hFF, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/universal_ff_bank.md
Name: universal_ff_bank

Overview:
- Parametrised bank of WIDTH flip-flops with a shared mode select: D, T, JK or SR behaviour.
- Mode is selectable every cycle.
- Adds clock enable, synchronous clear, a per-bit change report and a saturating change-event counter.
- General-purpose state element for control logic; replaces single-bit D/T flip-flop wrappers.

Parameters:
- WIDTH, 8, number of flip-flop bits (≥1)
- CNT_W, 16, width of change-event counter (≥1)
- RESET_VAL, {WIDTH{1'b0}}, value of Q after reset or clr

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  update enable; 0 = hold
- clr  input  1  synchronous clear to RESET_VAL
- mode  input  2  00=D, 01=T, 10=JK, 11=SR
- a  input  WIDTH  D / T / J / S per bit
- b  input  WIDTH  K / R per bit; ignored in D and T modes
- Q  output  WIDTH  registered state
- Qn  output  WIDTH  ~Q (combinational from Q)
- chg  output  WIDTH  registered; bits of Q that changed at the last clock edge
- chg_cnt  output  CNT_W  number of edges at which ≥1 bit changed due to en; saturating
- sr_err  output  1  only when UFF_SR_ERR_EN is defined (see Optional Feature)

Behaviour:
- Reset (async, immediate on reset=1, independent of clk):
  - Q=RESET_VAL, chg=0, chg_cnt=0, sr_err=0.
  - Holds while reset is asserted.
- Priority at each rising edge: reset > clr > en > hold.
- clr=1:
  - Q<=RESET_VAL; chg_cnt<=0.
  - chg<=Q^RESET_VAL, so bits changed by the clear are reported.
  - Counter does not count the clear.
  - mode, a and b are ignored.
- en=0, clr=0: Q holds; chg<=0; chg_cnt holds.
- en=1, clr=0: per bit i, next value qn[i] is:
  - D: qn=a[i]
  - T: qn=Q[i]^a[i]
  - JK: {a,b} = 00 hold, 01 reset to 0, 10 set to 1, 11 toggle
  - SR: {a,b} = 00 hold, 01 0, 10 1, 11 hold (illegal combination; state preserved)
- On every en=1 edge:
  - Q<=qn.
  - chg<=qn^Q.
  - If |(qn^Q), chg_cnt increments by 1, saturating at 2^CNT_W-1; otherwise it holds.
- Latency: one cycle from inputs to Q, chg and chg_cnt. All three update at the same edge.
- Qn always equals ~Q, including during reset.
- A mode change takes effect at the first edge it is sampled. There is no pipeline and no internal state beyond Q, chg, chg_cnt and sr_err.
- Reset asserted mid-operation aborts any update at once; counter and chg clear.
- Widths: chg_cnt arithmetic is CNT_W-bit unsigned with saturation. No wrap to 0 is permitted.

Optional Feature:
- Macro: UFF_SR_ERR_EN
- Defined:
  - Port sr_err exists.
  - At each edge with en=1, clr=0, mode=11: sr_err <= |(a&b), i.e. high for one cycle after any bit sees S=R=1.
  - Cleared to 0 on any other edge and on reset.
  - Q behaviour is unchanged (hold on illegal bits).
- Undefined:
  - Port sr_err and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then T mode, WIDTH=8: reset=1 for 2 cycles -> Q=00, chg_cnt=0. Release; en=1, mode=01, a=8'hFF for 3 edges -> Q = FF, 00, FF; chg=FF each cycle; chg_cnt=3.
- JK per-bit, start Q=8'h0F: mode=10, a=8'hF0, b=8'h3C -> Q=8'hF3, chg=8'hFC, chg_cnt+1. Then a=b=00 -> Q holds, chg=00, chg_cnt unchanged.
- SR illegal, start Q=8'hA5: mode=11, a=8'h81, b=8'h81 -> Q stays A5, chg=00. With UFF_SR_ERR_EN, sr_err=1 for exactly one cycle.
- Priority and clear, from Q=8'h3C with RESET_VAL=8'h00:
  - en=0, D mode, a=FF -> Q holds 3C.
  - clr=1 with en=1 -> Q=00, chg=3C, chg_cnt=0.
- Saturation: CNT_W=2, 5 consecutive T-mode toggles -> chg_cnt sequence 1,2,3,3,3.
- Async reset mid-run: assert reset between clock edges while toggling -> Q, chg, chg_cnt go to 0 immediately, without waiting for an edge. Deassert -> operation resumes at the next edge.
